// File: rtl/move_if.sv
// -----------------------------------------------------------------------------
// move_if
// Bundles the board-side button levels, the game-enable strobe and the
// conditioned move outputs of move_input_conditioner.
//   master : drives btn_* and enable, observes the moves and held levels
//   slave  : the conditioner itself
// Signals:
//   btn_left/right/up/down  raw asynchronous active-high button levels
//   enable                  game running; moves are suppressed when low
//   left/right/up/down      registered single-cycle move pulses
//   held[3:0]               debounced levels {left,right,up,down}
// -----------------------------------------------------------------------------
interface move_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       enable;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic [3:0] held;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, enable,
    input  left, right, up, down, held
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, enable,
    output left, right, up, down, held
  );
endinterface

// File: rtl/move_input_conditioner.sv
// -----------------------------------------------------------------------------
// move_input_conditioner
// Turns four raw push-buttons into clean single-cycle move commands for the
// moving-square controller: two-flop synchroniser, counter debounce, first
// press pulse with auto-repeat (left/right/down), edge-only rotate (up),
// left/right conflict suppression and an optional gravity tick on down.
//
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   io      move_if.slave (buttons, enable, move pulses, held levels)
//
// Build option: define MOVE_GRAVITY_EN to include the gravity counter that
// injects a down move every GRAVITY_CYCLES cycles while enable is high.
// Without it, down comes only from btn_down and GRAVITY_CYCLES is unused.
// -----------------------------------------------------------------------------
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 15_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int GRAVITY_CYCLES  = 25_000_000
) (
  input  logic  clk,
  input  logic  resetn,
  move_if.slave io
);
  localparam int CW   = 26;
  localparam int NREP = 3;  // buttons with auto-repeat: down, right, left

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] GRAV_LAST  = CW'(GRAVITY_CYCLES - 1);

  // Bit positions inside the 4-bit button vectors, matching held.
  localparam int BL = 3;
  localparam int BR = 2;
  localparam int BU = 1;
  localparam int BD = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rep_state_e;

  // Maps repeat-FSM slot k to its button bit.
  function automatic logic [1:0] rep_bit(input int k);
    case (k)
      0:       rep_bit = 2'(BD);
      1:       rep_bit = 2'(BR);
      default: rep_bit = 2'(BL);
    endcase
  endfunction

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d, stable_prev_q;
  logic [CW-1:0] db_cnt_q [4];
  logic [CW-1:0] db_cnt_d [4];
  rep_state_e    state_q  [NREP];
  rep_state_e    state_d  [NREP];
  logic [CW-1:0] tmr_q    [NREP];
  logic [CW-1:0] tmr_d    [NREP];
  logic [3:0]    rise, fall;
  logic [3:0]    req_raw;
  logic [3:0]    move_d, move_q;
  logic          grav_req;

  assign raw  = {io.btn_left, io.btn_right, io.btn_up, io.btn_down};
  assign rise = stable_q & ~stable_prev_q;
  assign fall = ~stable_q & stable_prev_q;

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
  // synchronised samples that disagree with the current stable level.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Repeat FSMs. Timer counts down to zero; a pulse is requested on the
  // cycle it reads zero, so loading N-1 gives exactly N cycles of spacing.
  // Disabling the game or releasing the button drops straight to IDLE.
  always_comb begin
    req_raw = '0;
    for (int k = 0; k < NREP; k++) begin
      state_d[k] = state_q[k];
      tmr_d[k]   = tmr_q[k];
      if (!io.enable || fall[rep_bit(k)]) begin
        state_d[k] = ST_IDLE;
        tmr_d[k]   = '0;
      end else begin
        case (state_q[k])
          ST_IDLE: begin
            if (rise[rep_bit(k)]) begin
              req_raw[rep_bit(k)] = 1'b1;
              tmr_d[k]            = DELAY_LAST;
              state_d[k]          = ST_DELAY;
            end
          end
          ST_DELAY, ST_REPEAT: begin
            if (tmr_q[k] == '0) begin
              req_raw[rep_bit(k)] = 1'b1;
              tmr_d[k]            = RATE_LAST;
              state_d[k]          = ST_REPEAT;
            end else begin
              tmr_d[k] = tmr_q[k] - 1'b1;
            end
          end
          default: begin
            state_d[k] = ST_IDLE;
            tmr_d[k]   = '0;
          end
        endcase
      end
    end
    // Rotate is edge-only: one request per debounced press.
    req_raw[BU] = io.enable & rise[BU];
  end

`ifdef MOVE_GRAVITY_EN
  logic [CW-1:0] grav_q, grav_d;

  // Any down request (manual or gravity) restarts the gravity interval, so
  // the next tick lands a full GRAVITY_CYCLES after the last down move.
  always_comb begin
    grav_req = io.enable && (grav_q == GRAV_LAST);
    if (!io.enable || grav_req || req_raw[BD]) begin
      grav_d = '0;
    end else begin
      grav_d = grav_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) grav_q <= '0;
    else         grav_q <= grav_d;
  end
`else
  logic unused_gravity;
  assign grav_req       = 1'b0;
  assign unused_gravity = ^GRAV_LAST;
`endif

  // Simultaneous left and right cancel each other; down merges manual and
  // gravity requests into a single pulse.
  always_comb begin
    move_d = req_raw;
    if (req_raw[BL] && req_raw[BR]) begin
      move_d[BL] = 1'b0;
      move_d[BR] = 1'b0;
    end
    move_d[BD] = req_raw[BD] | grav_req;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      move_q        <= '0;
      // NOTE: these arrays are a handful of flops, not a RAM, so they are
      // reset like any other state and nothing carries across a reset.
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      for (int k = 0; k < NREP; k++) begin
        state_q[k] <= ST_IDLE;
        tmr_q[k]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, which the two-flop synchroniser depends on.
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      move_q        <= move_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int k = 0; k < NREP; k++) begin
        state_q[k] <= state_d[k];
        tmr_q[k]   <= tmr_d[k];
      end
    end
  end

  assign io.left  = move_q[BL];
  assign io.right = move_q[BR];
  assign io.up    = move_q[BU];
  assign io.down  = move_q[BD];
  assign io.held  = stable_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_move_input_conditioner
// Directed bench for move_input_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3, GRAVITY_CYCLES=20. Stimulus pushes the
// cycle and value of every expected move pulse into a queue; an independent
// monitor pops and compares whenever any move output is high.
// cyc counts rising edges; all sampling and driving happens on falling edges,
// so "cyc == N" means "the cycle after rising edge N".
// With MOVE_GRAVITY_EN defined only the gravity scenario runs.
// -----------------------------------------------------------------------------
module tb_move_input_conditioner;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam int GC = 20;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  mv;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];

  move_if io ();

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .GRAVITY_CYCLES (GC)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .io    (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_cycle(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int unsigned c, input logic [3:0] mv);
    exp_q.push_back('{cyc: c, mv: mv});
  endtask

  // Scoreboard monitor: moves ordered {left,right,up,down}.
  always @(negedge clk) begin : monitor
    logic [3:0] mv;
    mv = {io.left, io.right, io.up, io.down};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missed_pulse: expected moves %b at cycle %0d, outputs stayed low",
               exp_q[0].mv, exp_q[0].cyc);
      exp_q.delete(0);
    end
    if (mv != 4'b0000) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check($sformatf("pulse@%0d", cyc), 32'(mv), 32'(exp_q[0].mv));
        exp_q.delete(0);
      end else begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse: moves %b at cycle %0d, none expected", mv, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, m;
    io.btn_left  = 1'b0;
    io.btn_right = 1'b0;
    io.btn_up    = 1'b0;
    io.btn_down  = 1'b0;
    io.enable    = 1'b0;
    resetn       = 1'b0;
    tick(3);
    check("reset_held", 32'(io.held), 32'h0);
    check("reset_moves", 32'({io.left, io.right, io.up, io.down}), 32'h0);
    resetn = 1'b1;
    tick(2);

`ifdef MOVE_GRAVITY_EN
    // Gravity: pulses every 20 cycles from enable; manual down at count 15
    // restarts the interval; manual coinciding with gravity gives one pulse.
    k = cyc;
    io.enable = 1'b1;
    expect_pulse(k + 20,  4'b0001);
    expect_pulse(k + 40,  4'b0001);
    expect_pulse(k + 60,  4'b0001);
    expect_pulse(k + 76,  4'b0001);
    expect_pulse(k + 96,  4'b0001);
    expect_pulse(k + 116, 4'b0001);
    expect_pulse(k + 136, 4'b0001);
    at_cycle(k + 69);
    io.btn_down = 1'b1;
    at_cycle(k + 75);
    check("grav_held_manual1", 32'(io.held), 32'h1);
    at_cycle(k + 77);
    io.btn_down = 1'b0;
    at_cycle(k + 83);
    check("grav_held_rel1", 32'(io.held), 32'h0);
    at_cycle(k + 109);
    io.btn_down = 1'b1;
    at_cycle(k + 115);
    check("grav_held_manual2", 32'(io.held), 32'h1);
    at_cycle(k + 117);
    io.btn_down = 1'b0;
    at_cycle(k + 123);
    check("grav_held_rel2", 32'(io.held), 32'h0);
    at_cycle(k + 140);
    io.enable = 1'b0;
    at_cycle(k + 170);
`else
    io.enable = 1'b1;

    // Bounce then press: toggling every 2 cycles never debounces.
    for (int i = 0; i < 12; i++) begin
      io.btn_left = ((i % 4) < 2);
      tick(1);
    end
    io.btn_left = 1'b1;
    k = cyc;
    expect_pulse(k + DB + 3, 4'b1000);
    at_cycle(k + DB + 1);
    check("bounce_held_before", 32'(io.held), 32'h0);
    at_cycle(k + DB + 2);
    check("bounce_held_after", 32'(io.held), 32'h8);
    at_cycle(k + 8);
    io.btn_left = 1'b0;
    at_cycle(k + 14);
    check("bounce_held_release", 32'(io.held), 32'h0);
    at_cycle(k + 30);

    // Hold right: first pulse, then +10, then every 3 until release.
    io.btn_right = 1'b1;
    k = cyc;
    expect_pulse(k + 7, 4'b0100);
    for (int n = 0; n < 12; n++) expect_pulse(k + 17 + 3 * n, 4'b0100);
    at_cycle(k + 6);
    check("hold_held_rise", 32'(io.held), 32'h4);
    at_cycle(k + 46);
    io.btn_right = 1'b0;
    at_cycle(k + 51);
    check("hold_held_last", 32'(io.held), 32'h4);
    at_cycle(k + 52);
    check("hold_held_fall", 32'(io.held), 32'h0);
    at_cycle(k + 65);

    // Conflict: left and right together never pulse.
    io.btn_left  = 1'b1;
    io.btn_right = 1'b1;
    k = cyc;
    at_cycle(k + 6);
    check("conflict_held", 32'(io.held), 32'hC);
    at_cycle(k + 30);
    io.btn_left  = 1'b0;
    io.btn_right = 1'b0;
    at_cycle(k + 36);
    check("conflict_held_rel", 32'(io.held), 32'h0);
    at_cycle(k + 45);

    // Rotate: one pulse for a 50-cycle hold.
    io.btn_up = 1'b1;
    k = cyc;
    expect_pulse(k + 7, 4'b0010);
    at_cycle(k + 6);
    check("up_held", 32'(io.held), 32'h2);
    at_cycle(k + 50);
    io.btn_up = 1'b0;
    at_cycle(k + 56);
    check("up_held_rel", 32'(io.held), 32'h0);
    at_cycle(k + 65);

    // Enable drop mid-repeat, re-enable while held, then re-press.
    io.btn_right = 1'b1;
    k = cyc;
    expect_pulse(k + 7,  4'b0100);
    expect_pulse(k + 17, 4'b0100);
    expect_pulse(k + 20, 4'b0100);
    at_cycle(k + 21);
    io.enable = 1'b0;
    at_cycle(k + 30);
    check("en_low_held", 32'(io.held), 32'h4);
    at_cycle(k + 35);
    io.enable = 1'b1;
    at_cycle(k + 60);
    io.btn_right = 1'b0;
    at_cycle(k + 66);
    check("en_held_rel", 32'(io.held), 32'h0);
    at_cycle(k + 75);
    io.btn_right = 1'b1;
    m = cyc;
    expect_pulse(m + 7, 4'b0100);
    at_cycle(m + 8);
    io.btn_right = 1'b0;
    at_cycle(m + 25);

    // Reset mid-repeat while a pulse is high.
    io.btn_left = 1'b1;
    k = cyc;
    expect_pulse(k + 7,  4'b1000);
    expect_pulse(k + 17, 4'b1000);
    expect_pulse(k + 20, 4'b1000);
    at_cycle(k + 20);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_moves", 32'({io.left, io.right, io.up, io.down}), 32'h0);
    check("rst_async_held", 32'(io.held), 32'h0);
    io.btn_left = 1'b0;
    at_cycle(k + 25);
    resetn = 1'b1;
    at_cycle(k + 45);
    check("rst_post_held", 32'(io.held), 32'h0);
`endif

    tick(2);
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missed_pulse: expected moves %b at cycle %0d, outputs stayed low",
               exp_q[0].mv, exp_q[0].cyc);
      exp_q.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
